// File: rtl/store_buffer_if.sv
// Store buffer bus: execute-stage store request side plus the data-memory
// write port.
// Handshakes (both sides): a transfer happens on a posedge where valid and
// ready are both high; the source holds its payload stable while valid is
// high and ready is low.
// The master modport is the environment (execute stage + memory); the slave
// modport is the store buffer itself.
interface store_buffer_if;
   logic [31:0] store_addr;
   logic [31:0] store_val;
   logic [1:0]  store_size;
   logic        store_valid;
   logic        store_ready;
   logic        store_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_wvalid;
   logic        mem_wready;

   modport master (
      output store_addr, store_val, store_size, store_valid, mem_wready,
      input  store_ready, store_err, mem_addr, mem_wdata, mem_wstrb, mem_wvalid
   );

   modport slave (
      input  store_addr, store_val, store_size, store_valid, mem_wready,
      output store_ready, store_err, mem_addr, mem_wdata, mem_wstrb, mem_wvalid
   );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: checks store alignment, builds byte-lane data/strobes and
// queues stores in a DEPTH-entry FIFO that drains to the memory write port.
// Optional store-to-load forwarding is enabled by defining the macro
// STORE_BUFFER_FORWARD_EN (adds load_addr, fwd_data, fwd_strb, fwd_hit).
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   store_buffer_if.slave              bus,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
`ifdef STORE_BUFFER_FORWARD_EN
   ,
   input  logic [31:0]                load_addr,
   output logic [31:0]                fwd_data,
   output logic [3:0]                 fwd_strb,
   output logic                       fwd_hit
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Entry storage: word address (bits 31:2), lane data and byte strobes.
   logic [29:0] ent_addr [DEPTH];
   logic [31:0] ent_data [DEPTH];
   logic [3:0]  ent_strb [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          err_q;

   logic        offer;
   logic        legal;
   logic        push;
   logic        pop;
   logic [31:0] lane_data;
   logic [3:0]  lane_strb;

   // Ready depends on registered occupancy only, so a pop never reopens a
   // full buffer within the same cycle.
   assign bus.store_ready = (count != CW'(DEPTH));
   assign empty           = (count == '0);
   assign offer           = bus.store_valid & bus.store_ready;
   assign push            = offer & legal;
   assign pop             = !empty & bus.mem_wready;

   assign bus.store_err  = err_q;
   assign bus.mem_wvalid = !empty;
   assign bus.mem_addr   = {ent_addr[rd_ptr], 2'b00};
   assign bus.mem_wdata  = ent_data[rd_ptr];
   assign bus.mem_wstrb  = ent_strb[rd_ptr];

   // Alignment check and byte-lane formation for the offered store.
   always_comb begin
      legal     = 1'b0;
      lane_data = bus.store_val;
      lane_strb = 4'h0;
      case (bus.store_size)
         2'd0: begin
            legal     = 1'b1;
            lane_data = {4{bus.store_val[7:0]}};
            lane_strb = 4'b0001 << bus.store_addr[1:0];
         end
         2'd1: begin
            legal     = !bus.store_addr[0];
            lane_data = {2{bus.store_val[15:0]}};
            lane_strb = 4'b0011 << bus.store_addr[1:0];
         end
         2'd2: begin
            legal     = (bus.store_addr[1:0] == 2'b00);
            lane_data = bus.store_val;
            lane_strb = 4'hF;
         end
         default: begin
            legal     = 1'b0;
            lane_data = bus.store_val;
            lane_strb = 4'h0;
         end
      endcase
   end

   // Pointers, occupancy and the one-cycle error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= offer & !legal;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payload write; contents need no reset because count gates use.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= bus.store_addr[31:2];
         ent_data[wr_ptr] <= lane_data;
         ent_strb[wr_ptr] <= lane_strb;
      end
   end

`ifdef STORE_BUFFER_FORWARD_EN
   logic [AW-1:0] fwd_idx;

   // Walk occupied entries oldest to youngest so younger bytes overwrite.
   always_comb begin
      fwd_data = '0;
      fwd_strb = '0;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr + AW'(i);
         if ((CW'(i) < count) && (ent_addr[fwd_idx] == load_addr[31:2])) begin
            for (int b = 0; b < 4; b++) begin
               if (ent_strb[fwd_idx][b]) fwd_data[8*b +: 8] = ent_data[fwd_idx][8*b +: 8];
            end
            fwd_strb = fwd_strb | ent_strb[fwd_idx];
         end
      end
   end

   assign fwd_hit = |fwd_strb;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: alignment, lane formation, FIFO order,
// full/backpressure, reset mid-drain and (optionally) forwarding.
module tb_store_buffer;

   logic       clk;
   logic       reset;
   logic       empty;
   logic [2:0] count;
   int         vectors;
   int         miscompares;

`ifdef STORE_BUFFER_FORWARD_EN
   logic [31:0] load_addr;
   logic [31:0] fwd_data;
   logic [3:0]  fwd_strb;
   logic        fwd_hit;
`endif

   store_buffer_if bus ();

   store_buffer #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .empty     (empty),
      .count     (count)
`ifdef STORE_BUFFER_FORWARD_EN
      ,
      .load_addr (load_addr),
      .fwd_data  (fwd_data),
      .fwd_strb  (fwd_strb),
      .fwd_hit   (fwd_hit)
`endif
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are changed and outputs sampled 1 time unit
   // after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
      bus.store_addr  = a;
      bus.store_val   = v;
      bus.store_size  = s;
      bus.store_valid = 1'b1;
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      reset           = 1'b1;
      bus.store_addr  = '0;
      bus.store_val   = '0;
      bus.store_size  = '0;
      bus.store_valid = 1'b0;
      bus.mem_wready  = 1'b0;
`ifdef STORE_BUFFER_FORWARD_EN
      load_addr = '0;
`endif
      step();
      step();
      reset = 1'b0;

      // Reset state
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ready", 32'(bus.store_ready), 32'd1);
      chk("rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
      chk("rst_err", 32'(bus.store_err), 32'd0);

      // Word store, memory always ready
      bus.mem_wready = 1'b1;
      offer(32'h100, 32'hDEADBEEF, 2'd2);
      step();
      bus.store_valid = 1'b0;
      chk("word_wvalid", 32'(bus.mem_wvalid), 32'd1);
      chk("word_addr", bus.mem_addr, 32'h100);
      chk("word_data", bus.mem_wdata, 32'hDEADBEEF);
      chk("word_strb", 32'(bus.mem_wstrb), 32'hF);
      step();
      chk("word_empty", 32'(empty), 32'd1);
      chk("word_count0", 32'(count), 32'd0);

      // Byte store to lane 3
      bus.mem_wready = 1'b0;
      offer(32'h203, 32'h000000AB, 2'd0);
      step();
      bus.store_valid = 1'b0;
      chk("byte_addr", bus.mem_addr, 32'h200);
      chk("byte_data", bus.mem_wdata, 32'hABABABAB);
      chk("byte_strb", 32'(bus.mem_wstrb), 32'b1000);
      bus.mem_wready = 1'b1;
      step();
      chk("byte_empty", 32'(empty), 32'd1);

      // Half store to upper half
      bus.mem_wready = 1'b0;
      offer(32'h202, 32'h00001234, 2'd1);
      step();
      bus.store_valid = 1'b0;
      chk("half_addr", bus.mem_addr, 32'h200);
      chk("half_data", bus.mem_wdata, 32'h12341234);
      chk("half_strb", 32'(bus.mem_wstrb), 32'b1100);
      bus.mem_wready = 1'b1;
      step();
      chk("half_empty", 32'(empty), 32'd1);

      // Misaligned half: rejected, one error pulse
      offer(32'h201, 32'h5555, 2'd1);
      step();
      bus.store_valid = 1'b0;
      chk("mis_err", 32'(bus.store_err), 32'd1);
      chk("mis_count", 32'(count), 32'd0);
      chk("mis_wvalid", 32'(bus.mem_wvalid), 32'd0);
      step();
      chk("mis_err_clr", 32'(bus.store_err), 32'd0);

      // Illegal size 3: rejected, one error pulse
      offer(32'h0, 32'h77, 2'd3);
      step();
      bus.store_valid = 1'b0;
      chk("ill_err", 32'(bus.store_err), 32'd1);
      chk("ill_count", 32'(count), 32'd0);
      step();
      chk("ill_err_clr", 32'(bus.store_err), 32'd0);

      // Fill with memory stalled (pointers wrap: three entries already used)
      bus.mem_wready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         offer(32'h10 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 2'd2);
         step();
      end
      offer(32'h20, 32'h55555555, 2'd2);
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready", 32'(bus.store_ready), 32'd0);
      chk("full_head_addr", bus.mem_addr, 32'h10);
      step();
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_head_addr", bus.mem_addr, 32'h10);
      chk("stall_head_data", bus.mem_wdata, 32'h11111111);
      chk("stall_err", 32'(bus.store_err), 32'd0);

      // One pop while full: concurrent offer must be refused
      bus.mem_wready = 1'b1;
      step();
      bus.store_valid = 1'b0;
      bus.mem_wready  = 1'b0;
      chk("pop_count", 32'(count), 32'd3);
      chk("pop_ready", 32'(bus.store_ready), 32'd1);
      chk("pop_head_addr", bus.mem_addr, 32'h14);
      chk("pop_head_data", bus.mem_wdata, 32'h22222222);

      // Drain remaining in order
      bus.mem_wready = 1'b1;
      step();
      chk("drain_addr1", bus.mem_addr, 32'h18);
      chk("drain_data1", bus.mem_wdata, 32'h33333333);
      step();
      chk("drain_addr2", bus.mem_addr, 32'h1C);
      chk("drain_data2", bus.mem_wdata, 32'h44444444);
      step();
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_nopush", 32'(count), 32'd0);

      // Reset with three pending entries
      bus.mem_wready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(32'h300 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i), 2'd2);
         step();
      end
      bus.store_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
      chk("mid_rst_ready", 32'(bus.store_ready), 32'd1);

`ifdef STORE_BUFFER_FORWARD_EN
      // Two bytes to the same lane: younger must win
      offer(32'h41, 32'h11, 2'd0);
      step();
      offer(32'h41, 32'h22, 2'd0);
      step();
      bus.store_valid = 1'b0;
      load_addr = 32'h40;
      #1;
      chk("fwd_strb", 32'(fwd_strb), 32'b0010);
      chk("fwd_byte1", 32'(fwd_data[15:8]), 32'h22);
      chk("fwd_hit", 32'(fwd_hit), 32'd1);
      load_addr = 32'h80;
      #1;
      chk("fwd_miss", 32'(fwd_hit), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
